// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data-memory port between the core load/store path
// (zero-latency, stalled when it loses) and a valid/ready host port (DMA, debug,
// loading) with a registered read return. Round-robin arbitration, with an
// optional host burst lock bounded by MAX_HOLD consecutive host grants.
// Optional feature: define DMEM_ARB_STATS_EN to build the contention counters.
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic              host_lock,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ready,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       stat_conflicts,
  output logic [31:0]       stat_core_stalls
);

  typedef enum logic {
    GRANT_CORE = 1'b0,
    GRANT_HOST = 1'b1
  } grant_e;

  localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

  grant_e            last_grant_r;
  grant_e            last_grant_nxt_s;
  logic [3:0]        hold_cnt_r;
  logic [3:0]        hold_cnt_nxt_s;
  logic              core_grant_s;
  logic              host_grant_s;
  logic              host_rvalid_r;
  logic [DATA_W-1:0] host_rdata_r;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_s;

  // Grant decision: single winner per cycle; lock keeps the host on top until MAX_HOLD.
  always_comb begin
    core_grant_s = 1'b0;
    host_grant_s = 1'b0;
    if (reset) begin
      core_grant_s = 1'b0;
      host_grant_s = 1'b0;
    end else if (core_req && host_req) begin
      if (host_lock && (last_grant_r == GRANT_HOST) && (hold_cnt_r < MAX_HOLD_C)) begin
        host_grant_s = 1'b1;
      end else if (last_grant_r == GRANT_HOST) begin
        core_grant_s = 1'b1;
      end else begin
        host_grant_s = 1'b1;
      end
    end else if (core_req) begin
      core_grant_s = 1'b1;
    end else if (host_req) begin
      host_grant_s = 1'b1;
    end else begin
      core_grant_s = 1'b0;
      host_grant_s = 1'b0;
    end
  end

  // Next arbitration state: remember the last winner, count consecutive host grants.
  always_comb begin
    last_grant_nxt_s = last_grant_r;
    hold_cnt_nxt_s   = 4'd0;
    if (host_grant_s) begin
      last_grant_nxt_s = GRANT_HOST;
      hold_cnt_nxt_s   = (hold_cnt_r < MAX_HOLD_C) ? (hold_cnt_r + 4'd1) : hold_cnt_r;
    end else if (core_grant_s) begin
      last_grant_nxt_s = GRANT_CORE;
      hold_cnt_nxt_s   = 4'd0;
    end else begin
      last_grant_nxt_s = last_grant_r;
      hold_cnt_nxt_s   = 4'd0;
    end
  end

  // Arbitration state register; core wins the first conflict after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_r <= GRANT_HOST;
      hold_cnt_r   <= 4'd0;
    end else begin
      last_grant_r <= last_grant_nxt_s;
      hold_cnt_r   <= hold_cnt_nxt_s;
    end
  end

  // Memory port mux: the winner drives the port, idle cycles park on core inputs.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_addr_s  = core_addr;
    mem_wdata_s = core_wdata;
    if (host_grant_s) begin
      mem_we_s    = host_we;
      mem_addr_s  = host_addr;
      mem_wdata_s = host_wdata;
    end else if (core_grant_s) begin
      mem_we_s    = core_we;
      mem_addr_s  = core_addr;
      mem_wdata_s = core_wdata;
    end else begin
      mem_we_s    = 1'b0;
      mem_addr_s  = core_addr;
      mem_wdata_s = core_wdata;
    end
  end

  // Host read return: capture memory data on the acceptance edge, pulse valid once.
  always_ff @(posedge clk) begin
    if (reset) begin
      host_rvalid_r <= 1'b0;
      host_rdata_r  <= {DATA_W{1'b0}};
    end else begin
      host_rvalid_r <= host_grant_s && !host_we;
      if (host_grant_s && !host_we) begin
        host_rdata_r <= mem_rdata;
      end else begin
        host_rdata_r <= host_rdata_r;
      end
    end
  end

  assign core_rdata  = mem_rdata;
  assign core_stall  = core_req && !core_grant_s;
  assign host_ready  = host_grant_s;
  assign host_rdata  = host_rdata_r;
  assign host_rvalid = host_rvalid_r;
  assign mem_we      = mem_we_s;
  assign mem_addr    = mem_addr_s;
  assign mem_wdata   = mem_wdata_s;

`ifdef DMEM_ARB_STATS_EN
  localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

  logic [31:0] stat_conflicts_r;
  logic [31:0] stat_core_stalls_r;

  // Saturating contention counters, frozen at zero while in reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_conflicts_r   <= 32'd0;
      stat_core_stalls_r <= 32'd0;
    end else begin
      if (core_req && host_req && (stat_conflicts_r != STAT_MAX)) begin
        stat_conflicts_r <= stat_conflicts_r + 32'd1;
      end else begin
        stat_conflicts_r <= stat_conflicts_r;
      end
      if (core_stall && (stat_core_stalls_r != STAT_MAX)) begin
        stat_core_stalls_r <= stat_core_stalls_r + 32'd1;
      end else begin
        stat_core_stalls_r <= stat_core_stalls_r;
      end
    end
  end

  assign stat_conflicts   = stat_conflicts_r;
  assign stat_core_stalls = stat_core_stalls_r;
`else
  assign stat_conflicts   = 32'd0;
  assign stat_core_stalls = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table plus randomized
// traffic compared against a behavioural model of the arbitration rules.
module tb_dmem_arbiter;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int MAX_HOLD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req, core_we;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        core_stall;
  logic        host_req, host_we, host_lock;
  logic [31:0] host_addr, host_wdata;
  logic        host_ready;
  logic [31:0] host_rdata;
  logic        host_rvalid;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] stat_conflicts, stat_core_stalls;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
    .host_req(host_req), .host_we(host_we), .host_lock(host_lock),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_ready(host_ready),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stat_conflicts(stat_conflicts), .stat_core_stalls(stat_core_stalls)
  );

  always #5 clk = ~clk;

  // Data memory: combinational read, write on the rising edge.
  logic [31:0] mem [0:1023];
  logic        mem_init;
  assign mem_rdata = mem[mem_addr[11:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h5A00_0000 | 32'(i);
      mem[128] <= 32'hDEAD_BEEF;
    end else if (mem_we) begin
      mem[mem_addr[11:2]] <= mem_wdata;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk1(input string name, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model state
  bit          m_last_host = 1'b1;
  int          m_run       = 0;
  logic        m_rvalid    = 1'b0;
  logic [31:0] m_rdata     = 32'd0;
  logic [31:0] m_conf      = 32'd0;
  logic [31:0] m_stall     = 32'd0;
  logic        e_cg, e_hg;
  int          core_wait   = 0;
  int          host_wait   = 0;

  // Combinational expectations for the inputs currently applied.
  task automatic model_comb();
    logic [31:0] ea, ew;
    logic        ewe;
    #1;
    if (reset) begin
      e_cg = 1'b0; e_hg = 1'b0;
    end else if (core_req && host_req) begin
      e_hg = !m_last_host || (host_lock && (m_run < MAX_HOLD));
      e_cg = !e_hg;
    end else begin
      e_cg = core_req; e_hg = host_req;
    end
    ea  = e_hg ? host_addr  : core_addr;
    ew  = e_hg ? host_wdata : core_wdata;
    ewe = e_hg ? host_we    : (e_cg && core_we);
    chk1 ("core_stall", core_stall, core_req && !e_cg);
    chk1 ("host_ready", host_ready, e_hg);
    chk1 ("mem_we", mem_we, ewe);
    chk32("mem_addr", mem_addr, ea);
    chk32("mem_wdata", mem_wdata, ew);
    chk32("core_rdata", core_rdata, mem[ea[11:2]]);
    if (reset) begin
      core_wait = 0; host_wait = 0;
    end else begin
      core_wait = (core_req && core_stall) ? core_wait + 1 : 0;
      host_wait = (host_req && !host_ready) ? host_wait + 1 : 0;
    end
    chk1("core_wait_bound", core_wait <= MAX_HOLD, 1'b1);
    chk1("host_wait_bound", host_wait <= 1, 1'b1);
  endtask

  // Advance the model one edge, clock the DUT and check registered outputs.
  task automatic model_adv();
    if (reset) begin
      m_last_host = 1'b1; m_run = 0; m_rvalid = 1'b0; m_rdata = 32'd0;
      m_conf = 32'd0; m_stall = 32'd0;
    end else begin
      if (e_hg) begin
        m_last_host = 1'b1; m_run++;
      end else begin
        if (e_cg) m_last_host = 1'b0;
        m_run = 0;
      end
      m_rvalid = e_hg && !host_we;
      if (m_rvalid) m_rdata = mem[host_addr[11:2]];
      if (core_req && host_req && m_conf != 32'hFFFF_FFFF) m_conf++;
      if (core_req && !e_cg && m_stall != 32'hFFFF_FFFF) m_stall++;
    end
    @(posedge clk);
    @(negedge clk);
    chk1 ("host_rvalid", host_rvalid, m_rvalid);
    chk32("host_rdata", host_rdata, m_rdata);
`ifdef DMEM_ARB_STATS_EN
    chk32("stat_conflicts", stat_conflicts, m_conf);
    chk32("stat_core_stalls", stat_core_stalls, m_stall);
`else
    chk32("stat_conflicts", stat_conflicts, 32'd0);
    chk32("stat_core_stalls", stat_core_stalls, 32'd0);
`endif
  endtask

  typedef struct {
    logic rst; logic creq; logic cwe; logic [31:0] caddr; logic [31:0] cwd;
    logic hreq; logic hwe; logic hlock; logic [31:0] haddr; logic [31:0] hwd;
    logic e_stall; logic e_ready; logic e_we; logic [31:0] e_addr; logic [31:0] e_wd;
    logic chk_crd; logic [31:0] e_crd; logic e_rvalid; logic chk_hrd; logic [31:0] e_hrd;
  } vec_t;

  vec_t tv[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mem_init = 1'b1;
    core_req = 1'b0; core_we = 1'b0; core_addr = 32'd0; core_wdata = 32'd0;
    host_req = 1'b0; host_we = 1'b0; host_lock = 1'b0; host_addr = 32'd0; host_wdata = 32'd0;

    // reset with both requesting, then alternating round-robin (lock off)
    tv.push_back('{1'b1,1'b1,1'b0,32'h10,32'h0, 1'b1,1'b1,1'b0,32'h500,32'h5555_0500, 1'b1,1'b0,1'b0,32'h10,32'h0, 1'b0,32'h0, 1'b0,1'b1,32'h0});
    tv.push_back('{1'b0,1'b1,1'b0,32'h10,32'h0, 1'b1,1'b1,1'b0,32'h500,32'h5555_0500, 1'b0,1'b0,1'b0,32'h10,32'h0, 1'b0,32'h0, 1'b0,1'b1,32'h0});
    tv.push_back('{1'b0,1'b1,1'b0,32'h10,32'h0, 1'b1,1'b1,1'b0,32'h500,32'h5555_0500, 1'b1,1'b1,1'b1,32'h500,32'h5555_0500, 1'b0,32'h0, 1'b0,1'b1,32'h0});
    tv.push_back('{1'b0,1'b1,1'b0,32'h10,32'h0, 1'b1,1'b1,1'b0,32'h504,32'h5555_0504, 1'b0,1'b0,1'b0,32'h10,32'h0, 1'b0,32'h0, 1'b0,1'b1,32'h0});
    tv.push_back('{1'b0,1'b1,1'b0,32'h10,32'h0, 1'b1,1'b1,1'b0,32'h504,32'h5555_0504, 1'b1,1'b1,1'b1,32'h504,32'h5555_0504, 1'b0,32'h0, 1'b0,1'b1,32'h0});
    // host-only locked writes: saturate the consecutive-grant count
    for (int k = 0; k < 4; k++) begin
      tv.push_back('{1'b0,1'b0,1'b0,32'h10,32'h0, 1'b1,1'b1,1'b1,32'h300 + 32'(4*k),32'h3333_0300 + 32'(4*k),
                     1'b0,1'b1,1'b1,32'h300 + 32'(4*k),32'h3333_0300 + 32'(4*k), 1'b0,32'h0, 1'b0,1'b1,32'h0});
    end
    // locked burst 0x100..0x110 against a core requesting every cycle
    tv.push_back('{1'b0,1'b1,1'b0,32'h20,32'h0, 1'b1,1'b1,1'b1,32'h100,32'h1111_0100, 1'b0,1'b0,1'b0,32'h20,32'h0, 1'b0,32'h0, 1'b0,1'b1,32'h0});
    for (int k = 0; k < 4; k++) begin
      tv.push_back('{1'b0,1'b1,1'b0,32'h20,32'h0, 1'b1,1'b1,1'b1,32'h100 + 32'(4*k),32'h1111_0100 + 32'(4*k),
                     1'b1,1'b1,1'b1,32'h100 + 32'(4*k),32'h1111_0100 + 32'(4*k), 1'b0,32'h0, 1'b0,1'b1,32'h0});
    end
    tv.push_back('{1'b0,1'b1,1'b0,32'h20,32'h0, 1'b1,1'b1,1'b1,32'h110,32'h1111_0110, 1'b0,1'b0,1'b0,32'h20,32'h0, 1'b0,32'h0, 1'b0,1'b1,32'h0});
    tv.push_back('{1'b0,1'b1,1'b0,32'h20,32'h0, 1'b1,1'b1,1'b1,32'h110,32'h1111_0110, 1'b1,1'b1,1'b1,32'h110,32'h1111_0110, 1'b0,32'h0, 1'b0,1'b1,32'h0});
    // core store then load-back, host idle
    tv.push_back('{1'b0,1'b1,1'b1,32'h40,32'hCAFE_F00D, 1'b0,1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,1'b1,32'h40,32'hCAFE_F00D, 1'b0,32'h0, 1'b0,1'b1,32'h0});
    tv.push_back('{1'b0,1'b1,1'b0,32'h40,32'h0, 1'b0,1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,1'b0,32'h40,32'h0, 1'b1,32'hCAFE_F00D, 1'b0,1'b1,32'h0});
    // host read of preloaded 0x200, core idle
    tv.push_back('{1'b0,1'b0,1'b0,32'h0,32'h0, 1'b1,1'b0,1'b0,32'h200,32'h0, 1'b0,1'b1,1'b0,32'h200,32'h0, 1'b0,32'h0, 1'b1,1'b1,32'hDEAD_BEEF});
    tv.push_back('{1'b0,1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,1'b0,32'h0,32'h0, 1'b0,32'h0, 1'b0,1'b0,32'h0});
    // host read presented while reset is high: no transfer, no rvalid, data cleared
    tv.push_back('{1'b1,1'b0,1'b0,32'h0,32'h0, 1'b1,1'b0,1'b0,32'h200,32'h0, 1'b0,1'b0,1'b0,32'h0,32'h0, 1'b0,32'h0, 1'b0,1'b1,32'h0});
    tv.push_back('{1'b0,1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,1'b0,32'h0,32'h0, 1'b0,32'h0, 1'b0,1'b1,32'h0});

    @(negedge clk); @(negedge clk); @(negedge clk);
    mem_init = 1'b0;

    for (int i = 0; i < tv.size(); i++) begin
      reset = tv[i].rst; core_req = tv[i].creq; core_we = tv[i].cwe;
      core_addr = tv[i].caddr; core_wdata = tv[i].cwd;
      host_req = tv[i].hreq; host_we = tv[i].hwe; host_lock = tv[i].hlock;
      host_addr = tv[i].haddr; host_wdata = tv[i].hwd;
      model_comb();
      chk1 ($sformatf("vec%0d core_stall", i), core_stall, tv[i].e_stall);
      chk1 ($sformatf("vec%0d host_ready", i), host_ready, tv[i].e_ready);
      chk1 ($sformatf("vec%0d mem_we", i), mem_we, tv[i].e_we);
      chk32($sformatf("vec%0d mem_addr", i), mem_addr, tv[i].e_addr);
      chk32($sformatf("vec%0d mem_wdata", i), mem_wdata, tv[i].e_wd);
      if (tv[i].chk_crd) chk32($sformatf("vec%0d core_rdata", i), core_rdata, tv[i].e_crd);
      model_adv();
      chk1($sformatf("vec%0d host_rvalid", i), host_rvalid, tv[i].e_rvalid);
      if (tv[i].chk_hrd) chk32($sformatf("vec%0d host_rdata", i), host_rdata, tv[i].e_hrd);
      if (i == 4) begin
`ifdef DMEM_ARB_STATS_EN
        chk32("alt stat_conflicts", stat_conflicts, 32'd4);
        chk32("alt stat_core_stalls", stat_core_stalls, 32'd2);
`else
        chk32("alt stat_conflicts", stat_conflicts, 32'd0);
        chk32("alt stat_core_stalls", stat_core_stalls, 32'd0);
`endif
      end
    end

    // Randomized traffic; host holds its inputs while waiting for ready.
    e_hg = 1'b0;
    for (int c = 0; c < 400; c++) begin
      reset      = ($urandom_range(0, 39) == 0);
      core_req   = ($urandom_range(0, 3) != 0);
      core_we    = ($urandom_range(0, 1) == 1);
      core_addr  = $urandom() & 32'hF000_0FFC;
      core_wdata = $urandom();
      if (!(host_req && !e_hg)) begin
        host_req   = ($urandom_range(0, 2) != 0);
        host_we    = ($urandom_range(0, 1) == 1);
        host_addr  = $urandom() & 32'hF000_0FFC;
        host_wdata = $urandom();
      end
      host_lock = ($urandom_range(0, 3) != 0);
      model_comb();
      model_adv();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
